// File: rtl/mult_norm_scheduler.sv
// Round-robin arbiter feeding a 2-stage stallable multiply-result normalizer.
// Results return in accept order, tagged with the requester index.
module mult_norm_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*9-1:0]  req_e,
    input  logic [NUM_REQ*16-1:0] req_m,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_e,
    output logic [6:0]            rsp_m,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  uf_sticky
);

    localparam logic [ID_W:0]   NumReqW = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [8:0]      r_s1_e;
    logic [15:0]     r_s1_m;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s2_valid;
    logic [7:0]      r_s2_e;
    logic [6:0]      r_s2_m;
    logic [ID_W-1:0] r_s2_id;
    logic            r_sticky;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W-1:0]      w_off;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_next_ptr;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic [8:0]           w_sel_e;
    logic [15:0]          w_sel_m;
    logic [3:0]           w_shift;
    logic [14:0]          w_m_shl;
    logic [7:0]           w_norm_e;
    logic [6:0]           w_norm_m;
    logic                 w_wrap;
    logic                 w_unused_bits;

    // Rotate so bit 0 is the requester the pointer points at; lowest set bit wins.
    assign w_dbl = {req_valid, req_valid} >> r_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = ID_W'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_winner   = (w_sum >= NumReqW) ? ID_W'(w_sum - NumReqW) : w_sum[ID_W-1:0];
    assign w_next_ptr = (w_winner == LastIdx) ? '0 : w_winner + 1'b1;

    assign w_s2_adv = !r_s2_valid || rsp_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = rst_n && !flush && w_found && w_s1_adv;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
        end
    end

    always_comb begin
        w_sel_e = '0;
        w_sel_m = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_e = req_e[i*9 +: 9];
                w_sel_m = req_m[i*16 +: 16];
            end
        end
    end

    // Zero mantissa leaves shift at 0, giving out_e = e and out_m = 0.
    always_comb begin
        w_shift = 4'd0;
        for (int b = 0; b < 15; b++) begin
            if (r_s1_m[b]) w_shift = 4'(14 - b);
        end
        w_m_shl = r_s1_m[14:0] << w_shift;
        w_wrap  = 1'b0;
        if (r_s1_e[8]) begin
            w_norm_e = 8'hFF;
            w_norm_m = '0;
        end else begin
            w_norm_e = r_s1_e[7:0] - {4'd0, w_shift};
            w_norm_m = w_m_shl[13:7];
            w_wrap   = r_s1_e[7:0] < {4'd0, w_shift};
        end
    end

    assign w_unused_bits = r_s1_m[15] ^ w_m_shl[14] ^ (^w_m_shl[6:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_e     <= '0;
            r_s1_m     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_e     <= '0;
            r_s2_m     <= '0;
            r_s2_id    <= '0;
            r_sticky   <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_e  <= w_norm_e;
                    r_s2_m  <= w_norm_m;
                    r_s2_id <= r_s1_id;
                    if (w_wrap) r_sticky <= 1'b1;
                end
            end
            if (w_s1_adv) r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_e  <= w_sel_e;
                r_s1_m  <= w_sel_m;
                r_s1_id <= w_winner;
                r_ptr   <= w_next_ptr;
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_e     = r_s2_e;
    assign rsp_m     = r_s2_m;
    assign rsp_id    = r_s2_id;
    assign uf_sticky = r_sticky;

endmodule

// File: tb/tb_mult_norm_scheduler.sv
// Randomized bench for mult_norm_scheduler against a queue-based reference model.
module tb_mult_norm_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*9-1:0]  req_e;
    logic [N*16-1:0] req_m;
    logic [N-1:0]    req_ready;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_e;
    logic [6:0]      rsp_m;
    logic [IW-1:0]   rsp_id;
    logic            uf_sticky;

    always #5 clk = ~clk;

    mult_norm_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_e     (req_e),
        .req_m     (req_m),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_e     (rsp_e),
        .rsp_m     (rsp_m),
        .rsp_id    (rsp_id),
        .uf_sticky (uf_sticky)
    );

    typedef struct {
        logic [7:0] e;
        logic [6:0] m;
        int         id;
        bit         wrap;
        bit         aged;
    } ent_t;

    ent_t        q[$];
    int          m_ptr;
    bit          m_sticky;
    bit          lv[N];
    bit          lane_off[N];
    logic [8:0]  le[N];
    logic [15:0] lm[N];
    int          budget;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Normalize by repeated doubling until the leading one reaches bit 14.
    function automatic void ref_norm(input logic [8:0] e, input logic [15:0] m,
                                     output logic [7:0] oe, output logic [6:0] om,
                                     output bit wrap);
        int mm;
        int sh;
        mm   = int'(m) & 32'h7fff;
        sh   = 0;
        wrap = 1'b0;
        if (e[8]) begin
            oe = 8'hFF;
            om = 7'd0;
            return;
        end
        if (mm == 0) begin
            oe = e[7:0];
            om = 7'd0;
            return;
        end
        while ((mm & 32'h4000) == 0) begin
            mm = mm << 1;
            sh++;
        end
        oe   = 8'((int'(e[7:0]) - sh) & 255);
        om   = 7'((mm >> 7) & 127);
        wrap = int'(e[7:0]) < sh;
    endfunction

    task automatic new_operands(input int i);
        le[i] = 9'($urandom);
        if ($urandom_range(0, 3) != 0) le[i][8] = 1'b0;
        lm[i] = 16'($urandom) >> $urandom_range(0, 16);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = lv[i];
            req_e[i*9 +: 9]     = le[i];
            req_m[i*16 +: 16]   = lm[i];
        end
    endtask

    task automatic step(input bit do_flush, input bit rdy);
        int         win;
        int         idx;
        bit         exp_v;
        logic [3:0] exp_rr;
        ent_t       ent;
        flush     = do_flush;
        rsp_ready = rdy;
        drive();
        @(negedge clk);
        win = -1;
        if (!do_flush && (q.size() < 2 || rdy)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && lv[idx]) win = idx;
            end
        end
        exp_rr = (win >= 0) ? 4'(1 << win) : 4'd0;
        check_eq("req_ready", req_ready, exp_rr);
        exp_v = q.size() > 0 && q[0].aged;
        check_eq("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            check_eq("rsp_e", rsp_e, q[0].e);
            check_eq("rsp_m", rsp_m, q[0].m);
            check_eq("rsp_id", rsp_id, q[0].id);
        end
        check_eq("uf_sticky", uf_sticky, m_sticky);
        @(posedge clk);
        if (do_flush) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            if (exp_v && rdy) void'(q.pop_front());
            for (int j = 0; j < q.size(); j++) q[j].aged = 1'b1;
            if (win >= 0) begin
                ref_norm(le[win], lm[win], ent.e, ent.m, ent.wrap);
                ent.id   = win;
                ent.aged = 1'b0;
                q.push_back(ent);
                m_ptr = (win + 1) % N;
                if (budget > 0) begin
                    budget--;
                    new_operands(win);
                end else begin
                    lv[win] = 1'b0;
                end
            end
            if (q.size() > 0 && q[0].aged && q[0].wrap) m_sticky = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (!lv[i] && !lane_off[i] && budget > 0 && $urandom_range(0, 1) == 1) begin
                budget--;
                new_operands(i);
                lv[i] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        budget = 0;
        repeat (12) step(1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            lv[i]       = 1'b1;
            lane_off[i] = 1'b0;
            new_operands(i);
        end
        m_ptr     = 0;
        m_sticky  = 1'b0;
        budget    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        drive();
        #3;
        check_eq("reset_req_ready", req_ready, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_e", rsp_e, 0);
        check_eq("reset_rsp_m", rsp_m, 0);
        check_eq("reset_rsp_id", rsp_id, 0);
        check_eq("reset_uf_sticky", uf_sticky, 0);
        for (int i = 0; i < N; i++) lv[i] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic normalization cases.
        lv[0] = 1'b1; le[0] = 9'h080; lm[0] = 16'h4000;
        repeat (4) step(1'b0, 1'b1);
        lv[2] = 1'b1; le[2] = 9'h085; lm[2] = 16'h0180;
        lv[1] = 1'b1; le[1] = 9'h1A0; lm[1] = 16'h7FFF;
        repeat (5) step(1'b0, 1'b1);

        // All requesters busy, then requester 1 drops out.
        budget = 1000;
        for (int i = 0; i < N; i++) begin
            lv[i] = 1'b1;
            new_operands(i);
        end
        repeat (8) step(1'b0, 1'b1);
        lane_off[1] = 1'b1;
        lv[1]       = 1'b0;
        repeat (6) step(1'b0, 1'b1);
        lane_off[1] = 1'b0;
        drain();

        // Six requests with a downstream stall.
        budget = 2;
        for (int i = 0; i < N; i++) begin
            lv[i] = 1'b1;
            new_operands(i);
        end
        for (int c = 0; c < 14; c++) step(1'b0, !(c >= 2 && c <= 6));
        drain();

        // Underflow wrap, then flush with an entry in flight.
        lv[3] = 1'b1; le[3] = 9'h003; lm[3] = 16'h0001;
        repeat (4) step(1'b0, 1'b1);
        lv[0] = 1'b1; le[0] = 9'h040; lm[0] = 16'h0123;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);

        // Randomized traffic with stalls and occasional flushes.
        budget = 100000;
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with both stages full.
        budget = 10;
        for (int i = 0; i < N; i++) begin
            lv[i] = 1'b1;
            new_operands(i);
        end
        repeat (4) step(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_rsp_e", rsp_e, 0);
        check_eq("midrst_rsp_m", rsp_m, 0);
        check_eq("midrst_rsp_id", rsp_id, 0);
        check_eq("midrst_uf_sticky", uf_sticky, 0);
        check_eq("midrst_req_ready", req_ready, 0);
        q.delete();
        m_ptr    = 0;
        m_sticky = 1'b0;
        budget   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) lv[i] = 1'b0;
        lv[1] = 1'b1; le[1] = 9'h090; lm[1] = 16'h0800;
        lv[3] = 1'b1; le[3] = 9'h011; lm[3] = 16'h0000;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        drive();
        #1;
        check_eq("postrst_grant", req_ready, 4'b0010);
        repeat (6) step(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
